alu_operand_stage: RTL and testbench

- Operand-fetch stage directly upstream of the 64-bit ALU: holds the 32-entry architectural register file and registers the ALU's inputs (data1, data2, select) for the next cycle.
- Reads two source registers, or one register plus an immediate, and presents them behind a valid/ready handshake.
- Accepts one write-back port from the end of the datapath.
- X31 is the hardwired zero register (XZR).

---
 rtl/alu_operand_stage_pkg.sv | 21 ++
 rtl/alu_operand_stage_if.sv | 35 +++
 rtl/alu_operand_stage_regfile.sv | 42 ++++
 rtl/alu_operand_stage.sv | 47 ++++
 tb/tb_alu_operand_stage.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand-fetch stage, its register file,
// and the ALU/decoder that agree on the select encodings.
package alu_operand_stage_pkg;
   localparam int BITSIZE = 64;
   localparam int REGSIZE = 32;
   localparam int ADDRW   = 5;
   localparam int SELW    = 3;

   localparam logic [ADDRW-1:0] XZR_ADDR = 5'd31;

   typedef enum logic [SELW-1:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_AND   = 3'b010,
      ALU_ORR   = 3'b011,
      ALU_EOR   = 3'b100,
      ALU_LSL   = 3'b101,
      ALU_LSR   = 3'b110,
      ALU_PASSB = 3'b111
   } alu_sel_e;
endpackage

// File: rtl/alu_operand_stage_if.sv
// Bundle of operation-issue, write-back and ALU-side signals of the stage.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its payload stable while valid && !ready.
interface alu_operand_stage_if;
   import alu_operand_stage_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [ADDRW-1:0]   rn_addr;
   logic [ADDRW-1:0]   rm_addr;
   logic [BITSIZE-1:0] imm;
   logic               use_imm;
   logic [SELW-1:0]    sel_in;
   logic               flush;
   logic               wr_en;
   logic [ADDRW-1:0]   wr_addr;
   logic [BITSIZE-1:0] wr_data;
   logic               out_ready;
   logic               out_valid;
   logic [BITSIZE-1:0] data1;
   logic [BITSIZE-1:0] data2;
   logic [SELW-1:0]    select;

   modport slave (
      input  in_valid, rn_addr, rm_addr, imm, use_imm, sel_in, flush,
             wr_en, wr_addr, wr_data, out_ready,
      output in_ready, out_valid, data1, data2, select
   );

   modport master (
      output in_valid, rn_addr, rm_addr, imm, use_imm, sel_in, flush,
             wr_en, wr_addr, wr_data, out_ready,
      input  in_ready, out_valid, data1, data2, select
   );
endinterface

// File: rtl/alu_operand_stage_regfile.sv
// 32-entry architectural register file: two bypassed combinational read
// ports, one write port, X31 reads as zero and ignores writes.
module alu_operand_stage_regfile
   import alu_operand_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [ADDRW-1:0]   wr_addr,
   input  logic [BITSIZE-1:0] wr_data,
   input  logic [ADDRW-1:0]   rd_addr_a,
   output logic [BITSIZE-1:0] rd_data_a,
   input  logic [ADDRW-1:0]   rd_addr_b,
   output logic [BITSIZE-1:0] rd_data_b
);
   logic [BITSIZE-1:0] regs [REGSIZE];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < REGSIZE; i++) regs[i] <= '0;
      end else if (wr_en && wr_addr != XZR_ADDR) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Same-cycle write-back is forwarded so a read is never one cycle stale.
   always_comb begin
      rd_data_a = regs[rd_addr_a];
      if (rd_addr_a == XZR_ADDR)
         rd_data_a = '0;
      else if (wr_en && wr_addr == rd_addr_a)
         rd_data_a = wr_data;
   end

   always_comb begin
      rd_data_b = regs[rd_addr_b];
      if (rd_addr_b == XZR_ADDR)
         rd_data_b = '0;
      else if (wr_en && wr_addr == rd_addr_b)
         rd_data_b = wr_data;
   end
endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: reads the register file (or immediate) and registers
// data1/data2/select for the ALU behind a valid/ready output register.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
(
   input logic                clk,
   input logic                rst,
   alu_operand_stage_if.slave bus
);
   logic [BITSIZE-1:0] rn_data;
   logic [BITSIZE-1:0] rm_data;
   logic               capture;

   alu_operand_stage_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .rd_addr_a (bus.rn_addr),
      .rd_data_a (rn_data),
      .rd_addr_b (bus.rm_addr),
      .rd_data_b (rm_data)
   );

   assign bus.in_ready = rst && (!bus.out_valid || bus.out_ready);
   assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

   // Priority: reset > flush > capture > drain; payload holds unless captured.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.out_valid <= 1'b0;
         bus.data1     <= '0;
         bus.data2     <= '0;
         bus.select    <= '0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (capture) begin
         bus.out_valid <= 1'b1;
         bus.data1     <= rn_data;
         bus.data2     <= bus.use_imm ? bus.imm : rm_data;
         bus.select    <= bus.sel_in;
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table with hand-derived
// expectations, then random traffic checked against a behavioural model.
module tb_alu_operand_stage;
   logic clk;
   logic rst;

   alu_operand_stage_if bus ();

   alu_operand_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic [63:0] wr_data;
      logic        in_valid;
      logic [4:0]  rn;
      logic [4:0]  rm;
      logic        use_imm;
      logic [63:0] imm;
      logic [2:0]  sel;
      logic        flush;
      logic        out_ready;
      logic        exp_ir;
      logic        exp_v;
      logic [63:0] exp_d1;
      logic [63:0] exp_d2;
      logic [2:0]  exp_sel;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model: architectural register contents and the ALU-side register.
   logic [63:0] m_r [32];
   logic        m_v;
   logic [63:0] m_d1, m_d2;
   logic [2:0]  m_sel;

   function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wa,
                               input logic [63:0] wd, input logic iv, input logic [4:0] rn,
                               input logic [4:0] rm, input logic ui, input logic [63:0] imm,
                               input logic [2:0] sel, input logic fl, input logic ordy,
                               input logic eir, input logic ev, input logic [63:0] ed1,
                               input logic [63:0] ed2, input logic [2:0] esel);
      vec_t v;
      v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.in_valid = iv;
      v.rn = rn; v.rm = rm; v.use_imm = ui; v.imm = imm; v.sel = sel; v.flush = fl;
      v.out_ready = ordy; v.exp_ir = eir; v.exp_v = ev; v.exp_d1 = ed1;
      v.exp_d2 = ed2; v.exp_sel = esel;
      return v;
   endfunction

   function automatic logic [63:0] mread(input logic [4:0] a, input vec_t v);
      if (a == 5'd31) return 64'd0;
      if (v.wr_en && v.wr_addr == a) return v.wr_data;
      return m_r[a];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step(input vec_t v, input bit use_tab);
      logic        ir, nv;
      logic [63:0] nd1, nd2;
      logic [2:0]  nsel;
      rst           = v.rst;
      bus.wr_en     = v.wr_en;
      bus.wr_addr   = v.wr_addr;
      bus.wr_data   = v.wr_data;
      bus.in_valid  = v.in_valid;
      bus.rn_addr   = v.rn;
      bus.rm_addr   = v.rm;
      bus.use_imm   = v.use_imm;
      bus.imm       = v.imm;
      bus.sel_in    = v.sel;
      bus.flush     = v.flush;
      bus.out_ready = v.out_ready;
      @(negedge clk);
      ir = v.rst && (!m_v || v.out_ready);
      check("in_ready", {63'd0, bus.in_ready}, {63'd0, use_tab ? v.exp_ir : ir});
      nv = m_v; nd1 = m_d1; nd2 = m_d2; nsel = m_sel;
      if (!v.rst) begin
         nv = 1'b0; nd1 = '0; nd2 = '0; nsel = '0;
      end else if (v.flush) begin
         nv = 1'b0;
      end else if (v.in_valid && ir) begin
         nv = 1'b1;
         nd1 = mread(v.rn, v);
         nd2 = v.use_imm ? v.imm : mread(v.rm, v);
         nsel = v.sel;
      end else if (m_v && v.out_ready) begin
         nv = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!v.rst) begin
         for (int i = 0; i < 32; i++) m_r[i] = '0;
      end else if (v.wr_en && v.wr_addr != 5'd31) begin
         m_r[v.wr_addr] = v.wr_data;
      end
      m_v = nv; m_d1 = nd1; m_d2 = nd2; m_sel = nsel;
      check("out_valid", {63'd0, bus.out_valid}, {63'd0, use_tab ? v.exp_v : m_v});
      check("data1", bus.data1, use_tab ? v.exp_d1 : m_d1);
      check("data2", bus.data2, use_tab ? v.exp_d2 : m_d2);
      check("select", {61'd0, bus.select}, {61'd0, use_tab ? v.exp_sel : m_sel});
   endtask

   vec_t tab [$];
   vec_t rv;

   initial begin
      m_v = 1'b0; m_d1 = '0; m_d2 = '0; m_sel = '0;
      for (int i = 0; i < 32; i++) m_r[i] = '0;
      rst = 1'b0;
      bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.in_valid = 0;
      bus.rn_addr = 0; bus.rm_addr = 0; bus.use_imm = 0; bus.imm = 0;
      bus.sel_in = 0; bus.flush = 0; bus.out_ready = 0;

      //        rst we wa  wd      iv rn  rm  ui imm    sel fl or eir ev d1      d2      sel
      tab.push_back(mk(0, 0, 0, 0,      0, 0,  0,  0, 0,     0, 0, 0, 0, 0, 0,      0,      0));
      tab.push_back(mk(0, 1, 6, 64'h33, 1, 0,  0,  0, 0,     0, 0, 1, 0, 0, 0,      0,      0));
      tab.push_back(mk(1, 1, 1, 13,     0, 0,  0,  0, 0,     0, 0, 1, 1, 0, 0,      0,      0));
      tab.push_back(mk(1, 1, 2, 1,      0, 0,  0,  0, 0,     0, 0, 1, 1, 0, 0,      0,      0));
      tab.push_back(mk(1, 0, 0, 0,      1, 1,  2,  0, 0,     0, 0, 1, 1, 1, 13,     1,      0));
      tab.push_back(mk(1, 1, 3, 64'hFF, 1, 3,  2,  0, 0,     2, 0, 1, 1, 1, 64'hFF, 1,      2));
      tab.push_back(mk(1, 1, 31, 5,     1, 31, 31, 0, 0,     0, 0, 1, 1, 1, 0,      0,      0));
      tab.push_back(mk(1, 0, 0, 0,      1, 1,  0,  1, 42,    1, 0, 1, 1, 1, 13,     42,     1));
      tab.push_back(mk(1, 0, 0, 0,      1, 2,  1,  0, 0,     3, 0, 0, 0, 1, 13,     42,     1));
      tab.push_back(mk(1, 0, 0, 0,      1, 2,  1,  0, 0,     3, 0, 0, 0, 1, 13,     42,     1));
      tab.push_back(mk(1, 0, 0, 0,      1, 2,  1,  0, 0,     3, 0, 0, 0, 1, 13,     42,     1));
      tab.push_back(mk(1, 0, 0, 0,      1, 2,  1,  0, 0,     3, 0, 1, 1, 1, 1,      13,     3));
      tab.push_back(mk(1, 1, 4, 7,      1, 1,  1,  0, 0,     6, 1, 1, 1, 0, 1,      13,     3));
      tab.push_back(mk(1, 0, 0, 0,      1, 4,  4,  0, 0,     5, 0, 1, 1, 1, 7,      7,      5));
      tab.push_back(mk(1, 0, 0, 0,      0, 0,  0,  0, 0,     0, 0, 1, 1, 0, 7,      7,      5));
      tab.push_back(mk(1, 0, 0, 0,      1, 6,  6,  0, 0,     7, 0, 1, 1, 1, 0,      0,      7));
      foreach (tab[i]) step(tab[i], 1'b1);

      // Reset while a stalled operation is held, then flush while stalled.
      step(mk(1, 0, 0, 0, 1, 1, 3, 0, 0, 2, 0, 1, 1, 1, 13, 64'hFF, 2), 1'b1);
      step(mk(1, 0, 0, 0, 1, 2, 2, 0, 0, 6, 0, 0, 0, 1, 13, 64'hFF, 2), 1'b1);
      step(mk(0, 1, 5, 9, 1, 2, 2, 0, 0, 6, 0, 0, 0, 0, 0,  0,      0), 1'b1);
      step(mk(1, 0, 0, 0, 1, 1, 5, 0, 0, 4, 0, 1, 1, 1, 0,  0,      4), 1'b1);
      step(mk(1, 0, 0, 0, 1, 4, 4, 0, 0, 5, 1, 0, 0, 0, 0,  0,      4), 1'b1);
      step(mk(1, 1, 4, 8, 1, 4, 3, 0, 0, 5, 0, 1, 1, 1, 8,  0,      5), 1'b1);

      for (int n = 0; n < 600; n++) begin
         rv.rst       = ($urandom_range(0, 49) != 0);
         rv.wr_en     = $urandom_range(0, 1);
         rv.wr_addr   = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         rv.wr_data   = {$urandom, $urandom};
         rv.in_valid  = ($urandom_range(0, 9) < 7);
         rv.rn        = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         rv.rm        = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         rv.use_imm   = $urandom_range(0, 1);
         rv.imm       = {$urandom, $urandom};
         rv.sel       = 3'($urandom_range(0, 7));
         rv.flush     = ($urandom_range(0, 9) == 0);
         rv.out_ready = ($urandom_range(0, 9) < 6);
         rv.exp_ir = 0; rv.exp_v = 0; rv.exp_d1 = 0; rv.exp_d2 = 0; rv.exp_sel = 0;
         step(rv, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
